// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial WIDTH-bit adder around one full_adder cell; SERIAL_ADD_SUB_EN adds a sub port for A-B
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             carry, sub_in, sub_r, fa_s, fa_c;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  full_adder u_fa (.A(a_sr[0]), .B(b_sr[0] ^ sub_r), .Cin(carry), .Sum(fa_s), .Cout(fa_c));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          sub_r <= sub_in;
          carry <= sub_in;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          res   <= (WIDTH-1)'({fa_s, res} >> 1);
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= {fa_s, res};
            cout  <= fa_c;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule
